// File: rtl/haze_atmos_light_est.sv
// Atmospheric light estimator: tracks the brightest dark-channel pixel per frame,
// then smooths, clamps and publishes its max(R,G,B) as per_A at frame end.
module haze_atmos_light_est #(
    parameter logic [7:0] A_INIT       = 8'd220,
    parameter logic [7:0] A_MIN        = 8'd100,
    parameter logic [7:0] A_MAX        = 8'd240,
    parameter int         SMOOTH_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_dark,
    input  logic [23:0] per_img,
    output logic [7:0]  per_A,
    output logic        a_valid,
    output logic        a_locked
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BLEND, S_WRITE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_vsync_d1;
    logic [7:0]  r_dark_max;
    logic [7:0]  r_a_max;
    logic        r_seen;
    logic        r_first;
    logic        r_pend;
    logic [7:0]  r_blend;
    logic [7:0]  r_per_A;
    logic        r_a_valid;
    logic        r_a_locked;

    logic        w_rise;
    logic        w_fall;
    logic        w_pix;
    logic        w_accept;
    logic        w_do_blend;
    logic        w_do_write;
    logic        w_hit;
    logic [7:0]  w_cand;
    logic [7:0]  w_dark_base;
    logic [7:0]  w_amax_base;
    logic [7:0]  w_blend_calc;
    logic [7:0]  w_clamped;

    assign w_rise = per_frame_vsync & ~r_vsync_d1;
    assign w_fall = ~per_frame_vsync & r_vsync_d1;
    assign w_pix  = per_frame_vsync & per_frame_href & per_frame_clken;

    always_comb begin
        w_cand = per_img[23:16];
        if (per_img[15:8] > w_cand) w_cand = per_img[15:8];
        if (per_img[7:0]  > w_cand) w_cand = per_img[7:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_next = S_ACCUM;
            S_ACCUM: if (w_fall) w_state_next = r_seen ? S_BLEND : S_IDLE;
            S_BLEND: w_state_next = S_WRITE;
            S_WRITE: w_state_next = (r_pend | w_rise) ? S_ACCUM : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control decode; a new frame may start while an update is still in flight
    always_comb begin
        w_accept   = w_pix & ((r_state == S_ACCUM) | w_rise | r_pend);
        w_do_blend = (r_state == S_BLEND);
        w_do_write = (r_state == S_WRITE);
    end

    assign w_dark_base = w_rise ? 8'd0 : r_dark_max;
    assign w_amax_base = w_rise ? 8'd0 : r_a_max;
    assign w_hit       = w_accept & (per_dark > w_dark_base);

    generate
        if (SMOOTH_SHIFT == 0) begin : g_no_smooth
            assign w_blend_calc = r_a_max;
        end else begin : g_smooth
            localparam int W = 8 + SMOOTH_SHIFT;
            localparam logic [W-1:0] MULT = W'((1 << SMOOTH_SHIFT) - 1);
            logic [W-1:0] w_sum;
            assign w_sum        = W'(r_per_A) * MULT + W'(r_a_max);
            assign w_blend_calc = w_sum[W-1:SMOOTH_SHIFT];
        end
    endgenerate

    always_comb begin
        w_clamped = r_blend;
        if (r_blend < A_MIN) w_clamped = A_MIN;
        if (r_blend > A_MAX) w_clamped = A_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d1 <= 1'b0;
            r_dark_max <= 8'd0;
            r_a_max    <= 8'd0;
            r_seen     <= 1'b0;
            r_first    <= 1'b1;
            r_pend     <= 1'b0;
            r_blend    <= 8'd0;
            r_per_A    <= A_INIT;
            r_a_valid  <= 1'b0;
            r_a_locked <= 1'b0;
        end else begin
            r_vsync_d1 <= per_frame_vsync;
            r_dark_max <= w_hit ? per_dark : w_dark_base;
            r_a_max    <= w_hit ? w_cand : w_amax_base;
            r_seen     <= w_accept | (r_seen & ~w_rise);
            if (w_do_blend && w_rise)
                r_pend <= 1'b1;
            else if (w_do_write)
                r_pend <= 1'b0;
            if (w_do_blend)
                r_blend <= (r_first || SMOOTH_SHIFT == 0) ? r_a_max : w_blend_calc;
            r_a_valid <= w_do_write;
            if (w_do_write) begin
                r_per_A    <= w_clamped;
                r_a_locked <= 1'b1;
                r_first    <= 1'b0;
            end
        end
    end

    assign per_A    = r_per_A;
    assign a_valid  = r_a_valid;
    assign a_locked = r_a_locked;
endmodule
